// File: rtl/stw_fault_list_encoder.sv
// Walks the STW BIST pass map one PE per cycle in row-major order and
// compacts failing PE coordinates into NUM_RU recompute-unit slots.
module stw_fault_list_encoder #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int NUM_RU = 4,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int NW    = $clog2(NUM_RU + 1)
) (
    input  logic                   gclk,
    input  logic                   grst_n,
    input  logic                   start,
    input  logic [ROWS*COLS-1:0]   stw_result,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_RU-1:0]      fault_valid,
    output logic [NUM_RU*RW-1:0]   fault_row,
    output logic [NUM_RU*CW-1:0]   fault_col,
    output logic [NW-1:0]          fault_count,
    output logic                   overflow
);

    localparam int NPE = ROWS * COLS;
    localparam int IW  = (NPE > 1) ? $clog2(NPE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NPE-1:0]          snap_q, snap_d;
    logic [NW-1:0]           cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic [NUM_RU-1:0]       vld_q, vld_d;
    logic [NUM_RU-1:0][RW-1:0] row_q, row_d;
    logic [NUM_RU-1:0][CW-1:0] col_q, col_d;

    logic [RW-1:0] cur_row;
    logic [CW-1:0] cur_col;

    assign cur_row = RW'(idx_q / IW'(COLS));
    assign cur_col = CW'(idx_q % IW'(COLS));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = stw_result;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    vld_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!snap_q[idx_q]) begin
                    if (cnt_q < NW'(NUM_RU)) begin
                        // Slot index equals the running count, so slots fill in discovery order.
                        for (int n = 0; n < NUM_RU; n++) begin
                            if (NW'(n) == cnt_q) begin
                                vld_d[n] = 1'b1;
                                row_d[n] = cur_row;
                                col_d[n] = cur_col;
                            end
                        end
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (idx_q == IW'(NPE - 1)) state_d = S_DONE;
                else                       idx_d   = idx_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            snap_q  <= '1;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign busy        = (state_q == S_SCAN);
    assign done        = (state_q == S_DONE);
    assign fault_valid = vld_q;
    assign fault_row   = row_q;
    assign fault_col   = col_q;
    assign fault_count = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_stw_fault_list_encoder.sv
// Scoreboard bench: a reference list is queued per accepted start and
// compared against the DUT outputs on the done pulse.
module tb_stw_fault_list_encoder;

    logic        gclk = 1'b0;
    logic        grst_n;
    logic        start;
    logic [15:0] stw_result;
    logic        busy, done;
    logic [3:0]  fault_valid;
    logic [7:0]  fault_row, fault_col;
    logic [2:0]  fault_count;
    logic        overflow;

    typedef struct packed {
        logic [3:0] vld;
        logic [7:0] row;
        logic [7:0] col;
        logic [2:0] cnt;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_seen = 0;

    stw_fault_list_encoder #(.ROWS(4), .COLS(4), .NUM_RU(4)) dut (
        .gclk(gclk), .grst_n(grst_n), .start(start), .stw_result(stw_result),
        .busy(busy), .done(done), .fault_valid(fault_valid), .fault_row(fault_row),
        .fault_col(fault_col), .fault_count(fault_count), .overflow(overflow)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] m);
        exp_t e;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            if (!m[i]) begin
                if (e.cnt < 3'd4) begin
                    e.vld[e.cnt]       = 1'b1;
                    e.row[e.cnt*2 +: 2] = 2'(i / 4);
                    e.col[e.cnt*2 +: 2] = 2'(i % 4);
                    e.cnt              = e.cnt + 3'd1;
                end else begin
                    e.ovf = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic chk_list(input string tag, input exp_t e);
        chk({tag, "_vld"}, 32'(fault_valid), 32'(e.vld));
        chk({tag, "_row"}, 32'(fault_row),   32'(e.row));
        chk({tag, "_col"}, 32'(fault_col),   32'(e.col));
        chk({tag, "_cnt"}, 32'(fault_count), 32'(e.cnt));
        chk({tag, "_ovf"}, 32'(overflow),    32'(e.ovf));
    endtask

    always @(negedge gclk) begin
        if (done === 1'b1) begin
            done_seen++;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk_list("done", sb.pop_front());
        end
    end

    task automatic run_scan(input logic [15:0] m, input int glitch, input int rst_at);
        int j;
        int busy_n;
        int d0;
        @(posedge gclk); #1;
        stw_result = m;
        start      = 1'b1;
        last_exp   = model(m);
        sb.push_back(last_exp);
        d0 = done_seen;
        @(posedge gclk); #1;
        start  = 1'b0;
        busy_n = 0;
        j      = 0;
        while (done !== 1'b1 && j < 40) begin
            if (busy === 1'b1) busy_n++;
            if (j == glitch) begin
                stw_result = 16'h0000;
                start      = 1'b1;
            end else if (j == glitch + 1) begin
                start = 1'b0;
            end
            if (j == rst_at) begin
                grst_n = 1'b0;
                @(posedge gclk); #1;
                chk("mid_rst_busy", 32'(busy), 32'd0);
                chk("mid_rst_done", 32'(done), 32'd0);
                chk_list("mid_rst", '0);
                grst_n = 1'b1;
                sb.delete();
                @(posedge gclk); #1;
                chk("post_rst_idle", 32'(busy), 32'd0);
                return;
            end
            @(posedge gclk); #1;
            j++;
        end
        chk("done_latency", 32'(j), 32'd16);
        chk("busy_cycles", 32'(busy_n), 32'd16);
        @(posedge gclk); #1;
        chk("done_pulse_low", 32'(done), 32'd0);
        chk("idle_busy_low", 32'(busy), 32'd0);
        stw_result = ~stw_result;
        repeat (3) @(posedge gclk);
        #1;
        chk("done_once", 32'(done_seen - d0), 32'd1);
        chk("no_requeue", 32'(busy), 32'd0);
        chk_list("idle_hold", last_exp);
    endtask

    initial begin
        logic [15:0] m;
        grst_n     = 1'b0;
        start      = 1'b1;
        stw_result = 16'h0000;
        repeat (2) @(posedge gclk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_list("rst", '0);
        start  = 1'b0;
        grst_n = 1'b1;
        @(posedge gclk); #1;
        chk("rst_no_scan", 32'(busy), 32'd0);

        run_scan(16'hFFFF, -1, -1);
        m = 16'hFFFF; m[6] = 1'b0; m[12] = 1'b0;
        run_scan(m, -1, -1);
        m = 16'hFFFF; m[0] = 1'b0; m[1] = 1'b0; m[5] = 1'b0; m[11] = 1'b0; m[15] = 1'b0;
        run_scan(m, -1, -1);
        run_scan(16'hEF7B, 3, -1);
        run_scan(16'h0000, -1, 5);
        run_scan(16'hFFFE, -1, -1);
        run_scan(16'h0000, -1, -1);
        for (int t = 0; t < 4; t++) run_scan(16'($urandom), -1, -1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
